mux_acc_ctrl: RTL and testbench

//   Controller plus accumulator stage that sits directly downstream of the 4-bit 2:1 mux (mux_21).
//   - Drives the mux select, consumes mux_out and accumulates operand pairs.
//   - Result: acc = cnt * (mux_in0 + mux_in1), computed by alternating sel 0/1 once per clock.
//   - Start/busy/done handshake towards the upstream controller.

---
 rtl/mux_acc_ctrl.sv | 99 +++++++++
 tb/tb_mux_acc_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux_acc_ctrl.sv
// Drives mux_21 select and accumulates cnt pairs of (mux_in0 + mux_in1) with a start/busy/done handshake.
// Define MUX_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mux_acc_ctrl #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4,
  parameter int ACC_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic [DATA_W-1:0] i_mux_out,
  output logic              o_sel,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD_A,
    S_ADD_B,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_rem;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_add;

  // One extra bit on the adder exposes the carry-out used for the overflow flag.
  assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, i_mux_out};
  assign w_carry = w_sum[ACC_W];

`ifdef MUX_ACC_SAT_EN
  assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_add = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_cnt == '0) ? S_DONE : S_ADD_A;
      end
      S_ADD_A: w_next = S_ADD_B;
      S_ADD_B: w_next = (r_rem == CNT_W'(1)) ? S_DONE : S_ADD_A;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Both add states share the same adder; only ADD_B consumes a pair from the remaining count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_rem <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_rem <= i_cnt;
          end
        end
        S_ADD_A: begin
          r_acc <= w_acc_add;
          if (w_carry) r_ovf <= 1'b1;
        end
        S_ADD_B: begin
          r_acc <= w_acc_add;
          r_rem <= r_rem - CNT_W'(1);
          if (w_carry) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_sel  = (r_state == S_ADD_B);
  assign o_busy = (r_state == S_ADD_A) || (r_state == S_ADD_B);
  assign o_done = (r_state == S_DONE);
  assign o_acc  = r_acc;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_mux_acc_ctrl.sv
// Directed bench for mux_acc_ctrl with a behavioural mux_21 in the loop and a result scoreboard.
// Build with MUX_ACC_SAT_EN defined to check the saturating variant.
module tb_mux_acc_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [3:0] i_cnt = 4'd0;
  logic [3:0] w_mux_out;
  logic       o_sel;
  logic [7:0] o_acc;
  logic       o_busy;
  logic       o_done;
  logic       o_ovf;
  logic [3:0] muxIn0 = 4'd0;
  logic [3:0] muxIn1 = 4'd0;

  typedef struct {
    logic [7:0] acc;
    logic       ovf;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   failures = 0;

  always #5 i_clk = ~i_clk;

  assign w_mux_out = o_sel ? muxIn1 : muxIn0;

  mux_acc_ctrl #(.DATA_W(4), .CNT_W(4), .ACC_W(8)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_cnt     (i_cnt),
    .i_mux_out (w_mux_out),
    .o_sel     (o_sel),
    .o_acc     (o_acc),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_ovf     (o_ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Accepts one run, checks it cycle by cycle, and returns in the DONE cycle.
  task automatic applyStimulus(input int cnt, input int glitchCycle);
    exp_t       e;
    logic [8:0] s;
    int         cycles;
    e.acc = 8'd0;
    e.ovf = 1'b0;
    for (int i = 0; i < 2 * cnt; i++) begin
      s = {1'b0, e.acc} + {5'd0, ((i % 2) == 1) ? muxIn1 : muxIn0};
      if (s[8]) begin
        e.ovf = 1'b1;
`ifdef MUX_ACC_SAT_EN
        e.acc = 8'hFF;
`else
        e.acc = s[7:0];
`endif
      end else begin
        e.acc = s[7:0];
      end
    end
    sbQ.push_back(e);

    @(negedge i_clk);
    checkOutput("idle_done", {31'd0, o_done}, 32'd0);
    checkOutput("idle_busy", {31'd0, o_busy}, 32'd0);
    i_start = 1'b1;
    i_cnt   = 4'(cnt);
    @(posedge i_clk);
    #1 i_start = 1'b0;
    cycles = 0;
    @(negedge i_clk);
    while (!o_done && cycles < 64) begin
      if (cycles == 0) begin
        checkOutput("acc_cleared", {24'd0, o_acc}, 32'd0);
        checkOutput("ovf_cleared", {31'd0, o_ovf}, 32'd0);
      end
      checkOutput("busy", {31'd0, o_busy}, 32'd1);
      checkOutput("sel", {31'd0, o_sel}, 32'(cycles % 2));
      if (cycles == glitchCycle) begin
        i_start = 1'b1;
        i_cnt   = 4'd5;
      end else if (cycles == glitchCycle + 1) begin
        i_start = 1'b0;
      end
      cycles++;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    checkOutput("latency", 32'(cycles), 32'(2 * cnt));
    checkOutput("done", {31'd0, o_done}, 32'd1);
    checkOutput("done_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("done_sel", {31'd0, o_sel}, 32'd0);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("acc", {24'd0, o_acc}, {24'd0, e.acc});
      checkOutput("ovf", {31'd0, o_ovf}, {31'd0, e.ovf});
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge i_clk);
    checkOutput("rst_acc", {24'd0, o_acc}, 32'd0);
    checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, o_done}, 32'd0);
    checkOutput("rst_sel", {31'd0, o_sel}, 32'd0);
    checkOutput("rst_ovf", {31'd0, o_ovf}, 32'd0);
    i_rst = 1'b0;

    muxIn0 = 4'd14;
    muxIn1 = 4'd2;
    applyStimulus(3, -1);

    applyStimulus(0, -1);

    muxIn0 = 4'd5;
    muxIn1 = 4'd6;
    applyStimulus(2, 1);

    muxIn0 = 4'd1;
    muxIn1 = 4'd2;
    @(negedge i_clk);
    i_start = 1'b1;
    i_cnt   = 4'd4;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("mid_busy", {31'd0, o_busy}, 32'd1);
    checkOutput("mid_sel", {31'd0, o_sel}, 32'd0);
    checkOutput("mid_acc", {24'd0, o_acc}, 32'd3);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("abort_acc", {24'd0, o_acc}, 32'd0);
    checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("abort_sel", {31'd0, o_sel}, 32'd0);
    checkOutput("abort_ovf", {31'd0, o_ovf}, 32'd0);
    checkOutput("abort_done", {31'd0, o_done}, 32'd0);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checkOutput("abort_no_done", {31'd0, o_done}, 32'd0);
    end

    muxIn0 = 4'd15;
    muxIn1 = 4'd15;
    applyStimulus(9, -1);

    // start raised while in DONE must be ignored, then taken in the following IDLE cycle.
    i_start = 1'b1;
    i_cnt   = 4'd1;
    muxIn0  = 4'd3;
    muxIn1  = 4'd4;
    applyStimulus(1, -1);

    @(negedge i_clk);
    checkOutput("final_done", {31'd0, o_done}, 32'd0);
    checkOutput("final_acc_hold", {24'd0, o_acc}, 32'd7);
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
